// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keyboard receiver.
//   ps2_state_e    : frame FSM states (IDLE, DATA, PARITY, STOP)
//   PS2_BREAK_CODE : scan-code prefix sent before a key-release code
//   PS2_EXT_CODE   : scan-code prefix for extended keys
//   odd_ones()     : true when a 9-bit data+parity word holds an odd count of ones
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } ps2_state_e;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    function automatic logic odd_ones(input logic [8:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter -- conditions the raw PS/2 lines for the frame FSM.
//   Both lines pass through 2-flop synchronizers. The synchronized clock
//   is glitch-filtered: the filtered level only changes after FILTER_LEN
//   consecutive synchronized samples that disagree with it. A 1->0 change
//   of the filtered clock produces a one-cycle fall pulse.
// Ports:
//   clk_i      : system clock (rising edge)
//   rst_i      : synchronous active-high reset
//   ps2_clk_i  : raw asynchronous PS/2 clock line
//   ps2_data_i : raw asynchronous PS/2 data line
//   fall_o     : one-cycle pulse on a filtered ps2 clock falling edge
//   data_o     : synchronized ps2 data, aligned with fall_o
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_o,
    output logic data_o
);

    localparam int unsigned FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);
    localparam logic [FW-1:0] CNT_LAST = FW'(FILTER_LEN - 1);

    logic [1:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    // Count consecutive samples that disagree with the filtered level;
    // any agreeing sample restarts the count, so short glitches are dropped.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        fall_d = 1'b0;
        if (clk_sync_q[1] != filt_q) begin
            if (cnt_q == CNT_LAST) begin
                filt_d = clk_sync_q[1];
                fall_d = filt_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= 1'b1;
            cnt_q       <= '0;
            fall_q      <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            fall_q      <= fall_d;
        end
    end

    assign fall_o = fall_q;
    assign data_o = data_sync_q[1];

endmodule

// File: rtl/ps2_key_rx.sv
// ps2_key_rx -- PS/2 keyboard scan-code receiver.
//   Receives 11-bit PS/2 frames (start 0, 8 data LSB first, odd parity,
//   stop 1) and presents each accepted byte on keyCode with a one-cycle
//   dataReady pulse. Errors are reported as one-cycle pulses.
// Configuration macro:
//   PS2_BREAK_FILTER_EN : when defined, an accepted 8'hF0 and the byte
//                         following it are swallowed (no keyCode update,
//                         no dataReady). 8'hE0 always passes through.
// Ports:
//   clk_50m   : the only clock (rising edge)
//   rst       : synchronous active-high reset
//   ps2_clk   : raw PS/2 clock line
//   ps2_data  : raw PS/2 data line
//   keyCode   : last accepted scan code, held until the next accept
//   dataReady : one-cycle pulse marking a new keyCode
//   parityErr : one-cycle pulse on parity failure
//   frameErr  : one-cycle pulse on bad start/stop bit or timeout
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50m,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keyCode,
    output logic       dataReady,
    output logic       parityErr,
    output logic       frameErr
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT_CYCLES);

    logic fall;
    logic sdata;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .clk_i      (clk_50m),
        .rst_i      (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .fall_o     (fall),
        .data_o     (sdata)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    key_q, key_d;
    logic          dr_q, dr_d;
    logic          pe_q, pe_d;
    logic          fe_q, fe_d;
    logic          accept;
    logic          timeout;
`ifdef PS2_BREAK_FILTER_EN
    logic          brk_q, brk_d;
`endif

    assign timeout = (state_q != IDLE) && !fall && (to_q >= TO_LAST);

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        key_d    = key_q;
        dr_d     = 1'b0;
        pe_d     = 1'b0;
        fe_d     = 1'b0;
        accept   = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        brk_d    = brk_q;
`endif

        // Idle-gap counter: cleared in IDLE and on every edge, saturating.
        if (state_q == IDLE || fall) begin
            to_d = '0;
        end else if (to_q != TO_SAT) begin
            to_d = to_q + 1'b1;
        end else begin
            to_d = to_q;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!sdata) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                        shift_d  = '0;
                    end else begin
                        fe_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {sdata, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = sdata;
                    state_d = STOP;
                end else if (timeout) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (!sdata) begin
                        fe_d = 1'b1;
                    end else if (odd_ones({par_q, shift_q})) begin
                        accept = 1'b1;
                    end else begin
                        pe_d = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
`ifdef PS2_BREAK_FILTER_EN
            // A break prefix arms the swallow flag; the released key's code
            // that follows clears it. Extended prefixes are delivered as-is.
            if (brk_q) begin
                brk_d = 1'b0;
            end else if (shift_q == PS2_BREAK_CODE) begin
                brk_d = 1'b1;
            end else begin
                key_d = shift_q;
                dr_d  = 1'b1;
            end
`else
            key_d = shift_q;
            dr_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q  <= IDLE;
            bitcnt_q <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            to_q     <= '0;
            key_q    <= '0;
            dr_q     <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            brk_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            to_q     <= to_d;
            key_q    <= key_d;
            dr_q     <= dr_d;
            pe_q     <= pe_d;
            fe_q     <= fe_d;
`ifdef PS2_BREAK_FILTER_EN
            brk_q    <= brk_d;
`endif
        end
    end

    assign keyCode   = key_q;
    assign dataReady = dr_q;
    assign parityErr = pe_q;
    assign frameErr  = fe_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
module tb_ps2_key_rx;

    localparam int HALF = 40;
    localparam int TO   = 2000;

    logic       clk_50m = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keyCode;
    logic       dataReady;
    logic       parityErr;
    logic       frameErr;

    int vectors = 0;
    int miscompares = 0;

    int dr_cnt = 0, pe_cnt = 0, fe_cnt = 0;
    int dr0, pe0, fe0;
    int overlap = 0, wide = 0;
    logic dr_prev = 1'b0, pe_prev = 1'b0, fe_prev = 1'b0;

    always #10 clk_50m = ~clk_50m;

    ps2_key_rx #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_50m   (clk_50m),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .keyCode   (keyCode),
        .dataReady (dataReady),
        .parityErr (parityErr),
        .frameErr  (frameErr)
    );

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge clk_50m) begin
        if (dataReady === 1'b1) dr_cnt++;
        if (parityErr === 1'b1) pe_cnt++;
        if (frameErr  === 1'b1) fe_cnt++;
        if ((int'(dataReady === 1'b1) + int'(parityErr === 1'b1) + int'(frameErr === 1'b1)) > 1)
            overlap++;
        if ((dataReady === 1'b1 && dr_prev) || (parityErr === 1'b1 && pe_prev) ||
            (frameErr === 1'b1 && fe_prev))
            wide++;
        dr_prev = (dataReady === 1'b1);
        pe_prev = (parityErr === 1'b1);
        fe_prev = (frameErr === 1'b1);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_50m);
        #2;
    endtask

    task automatic snap();
        dr0 = dr_cnt;
        pe0 = pe_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        cyc(HALF);
        ps2_clk = 1'b0;
        cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stp);
        ps2_data = 1'b1;
        cyc(HALF);
    endtask

    task automatic check_counts(input string name, input int edr, input int epe, input int efe);
        vectors++;
        if (dr_cnt - dr0 !== edr) begin
            miscompares++;
            $display("FAIL %s dataReady pulses: got %0d expected %0d", name, dr_cnt - dr0, edr);
        end
        vectors++;
        if (pe_cnt - pe0 !== epe) begin
            miscompares++;
            $display("FAIL %s parityErr pulses: got %0d expected %0d", name, pe_cnt - pe0, epe);
        end
        vectors++;
        if (fe_cnt - fe0 !== efe) begin
            miscompares++;
            $display("FAIL %s frameErr pulses: got %0d expected %0d", name, fe_cnt - fe0, efe);
        end
    endtask

    task automatic check_key(input string name, input logic [7:0] exp);
        vectors++;
        if (keyCode !== exp) begin
            miscompares++;
            $display("FAIL %s keyCode: got %02h expected %02h", name, keyCode, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(10);
        check_key("reset", 8'h00);
        vectors++;
        if ({dataReady, parityErr, frameErr} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset pulses: got %03b expected 000", {dataReady, parityErr, frameErr});
        end
        rst = 1'b0;
        cyc(20);
    endtask

    task automatic test_good_frame();
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_key("good_1C", 8'h1C);
        check_counts("good_1C", 1, 0, 0);
    endtask

    task automatic test_parity_err();
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        check_key("parity_err", 8'h1C);
        check_counts("parity_err", 0, 1, 0);
    endtask

    task automatic test_stop_err();
        snap();
        send_frame(8'h5A, 1'b1, 1'b0);
        check_key("stop_err", 8'h1C);
        check_counts("stop_err", 0, 0, 1);
    endtask

    task automatic test_back_to_back();
        snap();
        send_frame(8'h21, 1'b1, 1'b1);
        check_key("b2b_21", 8'h21);
        send_frame(8'h5A, 1'b1, 1'b1);
        check_key("b2b_5A", 8'h5A);
        check_counts("b2b", 2, 0, 0);
    endtask

    task automatic test_break();
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        check_key("break_F0", 8'h5A);
`else
        check_key("break_F0", 8'hF0);
`endif
        send_frame(8'h1C, 1'b0, 1'b1);
`ifdef PS2_BREAK_FILTER_EN
        check_key("break_1C", 8'h5A);
        check_counts("break", 0, 0, 0);
`else
        check_key("break_1C", 8'h1C);
        check_counts("break", 2, 0, 0);
`endif
        snap();
        send_frame(8'hE0, 1'b0, 1'b1);
        check_key("ext_E0", 8'hE0);
        check_counts("ext_E0", 1, 0, 0);
    endtask

    task automatic test_timeout();
        snap();
        // start bit + four data bits, then silence for 1.2x the timeout
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        cyc(TO * 12 / 10);
        check_counts("timeout", 0, 0, 1);
        snap();
        send_frame(8'h32, 1'b0, 1'b1);
        check_key("after_timeout_32", 8'h32);
        check_counts("after_timeout", 1, 0, 0);
    endtask

    task automatic test_glitch();
        snap();
        ps2_data = 1'b1;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(60);
        check_counts("glitch_high_data", 0, 0, 0);
        ps2_data = 1'b0;
        cyc(10);
        ps2_clk = 1'b0;
        cyc(3);
        ps2_clk = 1'b1;
        cyc(60);
        ps2_data = 1'b1;
        cyc(10);
        check_counts("glitch_low_data", 0, 0, 0);
        snap();
        send_frame(8'h45, 1'b0, 1'b1);
        check_key("after_glitch_45", 8'h45);
        check_counts("after_glitch", 1, 0, 0);
    endtask

    task automatic test_rst_midframe();
        snap();
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        ps2_data = 1'b1;
        rst = 1'b1;
        cyc(5);
        check_key("rst_mid", 8'h00);
        rst = 1'b0;
        cyc(20);
        check_counts("rst_mid", 0, 0, 0);
        snap();
        send_frame(8'h1C, 1'b0, 1'b1);
        check_key("after_rst_1C", 8'h1C);
        check_counts("after_rst", 1, 0, 0);
    endtask

    task automatic test_pulse_shape();
        vectors++;
        if (overlap !== 0) begin
            miscompares++;
            $display("FAIL pulse_overlap: got %0d cycles expected 0", overlap);
        end
        vectors++;
        if (wide !== 0) begin
            miscompares++;
            $display("FAIL pulse_width: got %0d multi-cycle pulses expected 0", wide);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_err();
        test_stop_err();
        test_back_to_back();
        test_break();
        test_timeout();
        test_glitch();
        test_rst_midframe();
        test_pulse_shape();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
